// File: rtl/mem_dumper.sv
// rtl/mem_dumper.sv - streams a latched DMem window out on a valid/ready port and keeps a running checksum.
// Optional feature: define DUMP_PARITY_EN to add the OutPar output (XOR of OutDat).
module mem_dumper #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Done,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Rdat,
  output logic [DATA_W-1:0] OutDat,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Finished,
`ifdef DUMP_PARITY_EN
  output logic              OutPar,
`endif
  output logic [DATA_W-1:0] Checksum
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [DATA_W-1:0] out_dat_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] checksum_q;
  logic              done_prev_q;
  logic              out_par_q;

  // done_prev_q resets low so a Done already high at reset release starts a dump.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_dat_q   <= '0;
      out_valid_q <= 1'b0;
      checksum_q  <= '0;
      done_prev_q <= 1'b0;
      out_par_q   <= 1'b0;
    end else begin
      done_prev_q <= Done;
      case (state_q)
        IDLE: begin
          if (Done && !done_prev_q) begin
            checksum_q  <= '0;
            remaining_q <= Count;
            if (Count == '0) begin
              state_q <= FIN;
            end else begin
              addr_q  <= StartAddr;
              state_q <= READ;
            end
          end
        end
        READ: begin
          out_dat_q   <= Rdat;
          out_par_q   <= ^Rdat;
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_valid_q && OutReady) begin
            checksum_q  <= checksum_q + out_dat_q;
            remaining_q <= remaining_q - 1'b1;
            out_valid_q <= 1'b0;
            if (remaining_q == (ADDR_W+1)'(1)) begin
              state_q <= FIN;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= READ;
            end
          end
        end
        FIN: begin
          if (!Done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Addr     = addr_q;
  assign OutDat   = out_dat_q;
  assign OutValid = out_valid_q;
  assign Checksum = checksum_q;
  assign Busy     = (state_q == READ) || (state_q == SEND);
  assign Finished = (state_q == FIN);

`ifdef DUMP_PARITY_EN
  assign OutPar = out_par_q;
`else
  logic unused_par;
  assign unused_par = out_par_q;
`endif

endmodule
